// File: rtl/exec_ctrl_if.sv
// Fetch/decode <-> execute handshake: decoded instruction in, fetch request and pc out.
interface exec_ctrl_if #(
  parameter int DATA_LEN = 8,
  parameter int PC_W     = 6
);
  logic                IS_ready;
  logic [3:0]          control_bus;
  logic [DATA_LEN-1:0] data;
  logic                en;
  logic [PC_W-1:0]     pc;

  // Execute side: consumes decoded instructions, drives fetch request and address.
  modport master (
    input  IS_ready, control_bus, data,
    output en, pc
  );

  // Fetch/decode side.
  modport slave (
    output IS_ready, control_bus, data,
    input  en, pc
  );
endinterface

// File: rtl/exec_ctrl.sv
// Execute/sequencing stage: requests one instruction per round-trip, executes it
// on an 8-bit accumulator plus a local data memory, and owns pc, flags and halt/error.
module exec_ctrl #(
  parameter int INST_CAP   = 20,
  parameter int DATA_LEN   = 8,
  parameter int DMEM_DEPTH = 256,
  parameter int TIMEOUT    = 15
) (
  input  logic                clk,
  input  logic                rstn,
  exec_ctrl_if.master         bus,
  output logic [DATA_LEN-1:0] acc,
  output logic                zf,
  output logic                cf,
  output logic                halted,
  output logic                err
);

  localparam int PC_W  = $clog2(INST_CAP) + 1;
  localparam int AW    = $clog2(DMEM_DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EXEC, S_HALT} state_e;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDI, OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
    OP_HALT, OP_JMP, OP_JZ, OP_JC, OP_ADDI, OP_NOT
  } op_e;

  state_e              state, state_n;
  op_e                 op_q;
  logic [DATA_LEN-1:0] imm_q;
  logic [PC_W-1:0]     pc_q, pc_n, pc_inc, tgt;
  logic [DATA_LEN-1:0] acc_n, mem_rd;
  logic                zf_n, cf_n, halted_n, err_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n, cnt_inc;
  logic                ld_inst, st_we, acc_wr, take_jmp, tgt_ok;
  logic [DATA_LEN:0]   res;
  logic [DATA_LEN-1:0] dmem [DMEM_DEPTH];

  // Carry-out add / borrow-out subtract; the extra MSB is the new cf.
  function automatic logic [DATA_LEN:0] add_sub(input logic [DATA_LEN-1:0] a,
                                                 input logic [DATA_LEN-1:0] b,
                                                 input logic                sub);
    if (sub) return {1'b0, a} - {1'b0, b};
    else     return {1'b0, a} + {1'b0, b};
  endfunction

  assign bus.en  = (state == S_REQ);
  assign bus.pc  = pc_q;
  assign mem_rd  = dmem[imm_q[AW-1:0]];
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign pc_inc  = (pc_q == PC_W'(INST_CAP - 1)) ? '0 : pc_q + PC_W'(1);
  // Targets wider than pc are truncated, narrower ones zero-extended.
  assign tgt     = PC_W'(imm_q);
  assign tgt_ok  = (tgt < PC_W'(INST_CAP));

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state, instruction execution and fault detection.
  always_comb begin
    state_n  = state;
    pc_n     = pc_q;
    acc_n    = acc;
    zf_n     = zf;
    cf_n     = cf;
    halted_n = halted;
    err_n    = err;
    cnt_n    = cnt_q;
    ld_inst  = 1'b0;
    st_we    = 1'b0;
    acc_wr   = 1'b0;
    take_jmp = 1'b0;
    res      = '0;
    case (state)
      S_IDLE: state_n = S_REQ;
      S_REQ:  state_n = S_WAIT;
      S_WAIT: begin
        if (bus.IS_ready) begin
          ld_inst = 1'b1;
          state_n = S_EXEC;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            err_n    = 1'b1;
            halted_n = 1'b1;
            state_n  = S_HALT;
          end
        end
      end
      S_EXEC: begin
        cnt_n   = '0;
        state_n = S_REQ;
        pc_n    = pc_inc;
        case (op_q)
          OP_NOP:  ;
          OP_LDI:  begin acc_n = imm_q;  cf_n = 1'b0; acc_wr = 1'b1; end
          OP_LD:   begin acc_n = mem_rd; cf_n = 1'b0; acc_wr = 1'b1; end
          OP_ST:   st_we = 1'b1;
          OP_ADD:  begin res = add_sub(acc, mem_rd, 1'b0); acc_n = res[DATA_LEN-1:0]; cf_n = res[DATA_LEN]; acc_wr = 1'b1; end
          OP_SUB:  begin res = add_sub(acc, mem_rd, 1'b1); acc_n = res[DATA_LEN-1:0]; cf_n = res[DATA_LEN]; acc_wr = 1'b1; end
          OP_AND:  begin acc_n = acc & mem_rd; cf_n = 1'b0; acc_wr = 1'b1; end
          OP_OR:   begin acc_n = acc | mem_rd; cf_n = 1'b0; acc_wr = 1'b1; end
          OP_HALT: begin pc_n = pc_q; halted_n = 1'b1; state_n = S_HALT; end
          OP_JMP:  take_jmp = 1'b1;
          OP_JZ:   take_jmp = zf;
          OP_JC:   take_jmp = cf;
          OP_ADDI: begin res = add_sub(acc, imm_q, 1'b0); acc_n = res[DATA_LEN-1:0]; cf_n = res[DATA_LEN]; acc_wr = 1'b1; end
          OP_NOT:  begin acc_n = ~acc; cf_n = 1'b0; acc_wr = 1'b1; end
          default: begin pc_n = pc_q; err_n = 1'b1; halted_n = 1'b1; state_n = S_HALT; end
        endcase
        if (take_jmp) begin
          if (tgt_ok) begin
            pc_n = tgt;
          end else begin
            pc_n     = pc_q;
            err_n    = 1'b1;
            halted_n = 1'b1;
            state_n  = S_HALT;
          end
        end
        if (acc_wr) zf_n = (acc_n == '0);
      end
      default: ;
    endcase
  end

  // Architectural state: pc, accumulator, flags, status and WAIT timeout counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q   <= '0;
      acc    <= '0;
      zf     <= 1'b0;
      cf     <= 1'b0;
      halted <= 1'b0;
      err    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_n;
      acc    <= acc_n;
      zf     <= zf_n;
      cf     <= cf_n;
      halted <= halted_n;
      err    <= err_n;
      cnt_q  <= cnt_n;
    end
  end

  // Capture the decoded instruction when it is accepted in WAIT.
  always_ff @(posedge clk) begin
    if (ld_inst) begin
      op_q  <= op_e'(bus.control_bus);
      imm_q <= bus.data;
    end
  end

  // Data memory write; st_we only exists in EXEC, which reset leaves immediately.
  always_ff @(posedge clk) begin
    if (st_we) dmem[imm_q[AW-1:0]] <= acc;
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl with a small fetch/decode responder.
module tb_exec_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] acc;
  logic       zf, cf, halted, err;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         en_cyc = 0;
  int         prev_en_cyc = 0;

  exec_ctrl_if #(.DATA_LEN(8), .PC_W(6)) bus ();

  exec_ctrl #(.INST_CAP(20), .DATA_LEN(8), .DMEM_DEPTH(256), .TIMEOUT(15)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .acc(acc), .zf(zf), .cf(cf), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rstn = 1'b0;
    bus.IS_ready = 1'b0;
    bus.control_bus = 4'b1000;
    bus.data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Wait (bounded) for a negedge where en is high.
  task automatic wait_en(output bit ok);
    int n = 0;
    @(negedge clk);
    while (bus.en !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    ok = (bus.en === 1'b1);
    checks++;
    if (!ok) begin errors++; $display("FAIL en_request got en=%b want 1", bus.en); end
    else begin prev_en_cyc = en_cyc; en_cyc = cyc; end
  endtask

  // Answer one fetch: IS_ready in the third WAIT cycle; returns just after EXEC commits.
  task automatic fetch(input logic [3:0] op, input logic [7:0] imm);
    bit ok;
    wait_en(ok);
    if (ok) begin
      repeat (3) @(posedge clk);
      #1 bus.IS_ready = 1'b1; bus.control_bus = op; bus.data = imm;
      @(posedge clk);
      #1 bus.IS_ready = 1'b0; bus.control_bus = 4'b1000;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.en !== 1'b0) begin errors++; $display("FAIL rst_en got %b want 0", bus.en); end
    checks++; if (bus.pc !== 6'd0) begin errors++; $display("FAIL rst_pc got %0d want 0", bus.pc); end
    checks++; if ({acc, zf, cf, halted, err} !== 12'h000) begin errors++; $display("FAIL rst_state got acc=%h zf=%b cf=%b h=%b e=%b want all 0", acc, zf, cf, halted, err); end
  endtask

  task automatic test_basic();
    fetch(4'h1, 8'd5);
    checks++; if (acc !== 8'd5 || bus.pc !== 6'd1) begin errors++; $display("FAIL ldi got acc=%h pc=%0d want 05 1", acc, bus.pc); end
    fetch(4'hC, 8'd3);
    checks++; if ({acc, zf, cf} !== {8'd8, 1'b0, 1'b0} || bus.pc !== 6'd2) begin errors++; $display("FAIL addi got acc=%h zf=%b cf=%b pc=%0d want 08 0 0 2", acc, zf, cf, bus.pc); end
    checks++; if (en_cyc - prev_en_cyc !== 5) begin errors++; $display("FAIL en_period got %0d want 5", en_cyc - prev_en_cyc); end
  endtask

  task automatic test_carry_jump();
    fetch(4'h1, 8'hF0);
    fetch(4'hC, 8'h20);
    checks++; if ({acc, zf, cf} !== {8'h10, 1'b0, 1'b1} || bus.pc !== 6'd4) begin errors++; $display("FAIL addi_carry got acc=%h zf=%b cf=%b pc=%0d want 10 0 1 4", acc, zf, cf, bus.pc); end
    fetch(4'hB, 8'd7);
    checks++; if (bus.pc !== 6'd7) begin errors++; $display("FAIL jc_taken got pc=%0d want 7", bus.pc); end
    fetch(4'h1, 8'h01);
    checks++; if (cf !== 1'b0) begin errors++; $display("FAIL ldi_clr_cf got cf=%b want 0", cf); end
    fetch(4'hB, 8'd7);
    checks++; if (bus.pc !== 6'd9) begin errors++; $display("FAIL jc_not_taken got pc=%0d want 9", bus.pc); end
    fetch(4'h1, 8'h00);
    fetch(4'hA, 8'd3);
    checks++; if (bus.pc !== 6'd3 || zf !== 1'b1) begin errors++; $display("FAIL jz_taken got pc=%0d zf=%b want 3 1", bus.pc, zf); end
  endtask

  task automatic test_mem();
    fetch(4'h1, 8'h3C);
    fetch(4'h3, 8'd9);
    fetch(4'h1, 8'h00);
    fetch(4'h2, 8'd9);
    checks++; if ({acc, zf, cf} !== {8'h3C, 1'b0, 1'b0}) begin errors++; $display("FAIL ld got acc=%h zf=%b cf=%b want 3c 0 0", acc, zf, cf); end
    fetch(4'h5, 8'd9);
    checks++; if ({acc, zf, cf} !== {8'h00, 1'b1, 1'b0} || bus.pc !== 6'd8) begin errors++; $display("FAIL sub_zero got acc=%h zf=%b cf=%b pc=%0d want 00 1 0 8", acc, zf, cf, bus.pc); end
    fetch(4'h1, 8'h10);
    fetch(4'h5, 8'd9);
    checks++; if ({acc, zf, cf} !== {8'hD4, 1'b0, 1'b1}) begin errors++; $display("FAIL sub_borrow got acc=%h zf=%b cf=%b want d4 0 1", acc, zf, cf); end
    fetch(4'h1, 8'h0F);
    fetch(4'h7, 8'd9);
    checks++; if ({acc, cf} !== {8'h3F, 1'b0}) begin errors++; $display("FAIL or got acc=%h cf=%b want 3f 0", acc, cf); end
    fetch(4'h6, 8'd9);
    checks++; if (acc !== 8'h3C) begin errors++; $display("FAIL and got acc=%h want 3c", acc); end
    fetch(4'hD, 8'h00);
    checks++; if (acc !== 8'hC3) begin errors++; $display("FAIL not got acc=%h want c3", acc); end
    fetch(4'h4, 8'd9);
    checks++; if ({acc, cf} !== {8'hFF, 1'b0}) begin errors++; $display("FAIL add got acc=%h cf=%b want ff 0", acc, cf); end
    fetch(4'hC, 8'h01);
    checks++; if ({acc, zf, cf} !== {8'h00, 1'b1, 1'b1} || bus.pc !== 6'd16) begin errors++; $display("FAIL addi_wrap got acc=%h zf=%b cf=%b pc=%0d want 00 1 1 16", acc, zf, cf, bus.pc); end
  endtask

  task automatic test_wrap_jmp();
    int en_seen = 0;
    fetch(4'h9, 8'd19);
    checks++; if (bus.pc !== 6'd19) begin errors++; $display("FAIL jmp19 got pc=%0d want 19", bus.pc); end
    fetch(4'h0, 8'h00);
    checks++; if (bus.pc !== 6'd0) begin errors++; $display("FAIL pc_wrap got pc=%0d want 0", bus.pc); end
    fetch(4'h9, 8'd25);
    checks++; if ({err, halted} !== 2'b11 || bus.pc !== 6'd0 || acc !== 8'h00) begin errors++; $display("FAIL bad_jmp got err=%b halted=%b pc=%0d acc=%h want 1 1 0 00", err, halted, bus.pc, acc); end
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (bus.en !== 1'b0) en_seen++; end
    checks++; if (en_seen !== 0) begin errors++; $display("FAIL halt_en got %0d pulses want 0", en_seen); end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    wait_en(ok);
    repeat (15) @(posedge clk);
    #1;
    checks++; if ({err, halted} !== 2'b00) begin errors++; $display("FAIL timeout_early got err=%b halted=%b want 0 0", err, halted); end
    @(posedge clk);
    #1;
    checks++; if ({err, halted, bus.en} !== 3'b110) begin errors++; $display("FAIL timeout got err=%b halted=%b en=%b want 1 1 0", err, halted, bus.en); end
    do_reset();
    fetch(4'hE, 8'h00);
    checks++; if ({err, halted} !== 2'b11 || bus.pc !== 6'd0 || acc !== 8'h00) begin errors++; $display("FAIL illegal got err=%b halted=%b pc=%0d acc=%h want 1 1 0 00", err, halted, bus.pc, acc); end
    do_reset();
    fetch(4'h1, 8'h07);
    fetch(4'h8, 8'h00);
    repeat (6) @(posedge clk);
    #1;
    checks++; if ({err, halted} !== 2'b01 || bus.pc !== 6'd1 || acc !== 8'h07 || bus.en !== 1'b0) begin errors++; $display("FAIL halt_op got err=%b halted=%b pc=%0d acc=%h en=%b want 0 1 1 07 0", err, halted, bus.pc, acc, bus.en); end
  endtask

  task automatic test_ignore_reset();
    bit ok;
    do_reset();
    wait_en(ok);
    bus.IS_ready = 1'b1; bus.control_bus = 4'h1; bus.data = 8'h55;
    @(posedge clk);
    #1 bus.IS_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.IS_ready = 1'b1; bus.control_bus = 4'h1; bus.data = 8'h11;
    @(posedge clk);
    #1 bus.data = 8'h55;
    @(posedge clk);
    #1 bus.IS_ready = 1'b0; bus.control_bus = 4'b1000;
    checks++; if (acc !== 8'h11 || bus.pc !== 6'd1) begin errors++; $display("FAIL ignore_req got acc=%h pc=%0d want 11 1", acc, bus.pc); end
    fetch(4'h0, 8'h00);
    checks++; if (acc !== 8'h11 || bus.pc !== 6'd2) begin errors++; $display("FAIL ignore_exec got acc=%h pc=%0d want 11 2", acc, bus.pc); end
    fetch(4'h1, 8'hA0);
    fetch(4'hC, 8'h80);
    wait_en(ok);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    checks++; if ({bus.en, acc, zf, cf, halted, err} !== 13'h0 || bus.pc !== 6'd0) begin errors++; $display("FAIL wait_reset got en=%b pc=%0d acc=%h zf=%b cf=%b h=%b e=%b want all 0", bus.en, bus.pc, acc, zf, cf, halted, err); end
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    checks++; if (bus.en !== 1'b0) begin errors++; $display("FAIL post_rst_idle got en=%b want 0", bus.en); end
    @(negedge clk);
    checks++; if (bus.en !== 1'b1) begin errors++; $display("FAIL post_rst_req got en=%b want 1", bus.en); end
  endtask

  initial begin
    bus.IS_ready = 1'b0;
    bus.control_bus = 4'b1000;
    bus.data = 8'h00;
    test_reset();
    test_basic();
    test_carry_jump();
    test_mem();
    test_wrap_jmp();
    test_timeout();
    test_ignore_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
